ad_sch: RTL and testbench
=========================

AD_SCH -- requirements
Module: ad_sch

Interface
REQ-001 Parameter: DW, 24, sample width in bits for every channel and for the output.
REQ-002 Parameter: CNT_W, 16, width of each per-channel drop counter.
REQ-003 Port: clk_sys  input  1  system clock; all logic is on the rising edge.
REQ-004 Port: rst  input  1  reset; synchronous, active-high.
REQ-005 Port: ch_data  input  4*DW  sample data; channel i occupies bits [i*DW +: DW].
REQ-006 Port: ch_vld  input  4  single-cycle sample strobe, one bit per channel.
REQ-007 Port: cfg_ch_en  input  4  channel enable mask.
REQ-008 Port: ovf_clr  input  1  single-cycle clear of all overflow flags and drop counters.
REQ-009 Port: out_data  output  DW  scheduled sample.
REQ-010 Port: out_ch  output  2  source channel index of out_data.
REQ-011 Port: out_vld  output  1  output valid.
REQ-012 Port: out_rdy  input  1  downstream ready.
REQ-013 Port: ovf  output  4  sticky per-channel overflow flags.
REQ-014 Port: drop_cnt  output  4*CNT_W  per-channel drop counters; channel i occupies bits [i*CNT_W +: CNT_W].

Function
REQ-015 Each channel SHALL have a one-deep holding register and a pend flag.
REQ-016 When ch_vld[i] and cfg_ch_en[i] are both high in cycle N, ch_data[i] SHALL be captured, and pend[i] SHALL be 1 in cycle N+1.
REQ-017 A ch_vld[i] pulse that arrives while cfg_ch_en[i]=0 SHALL be ignored: no capture, no overflow.
REQ-018 The output slot is free when out_vld=0, or when out_vld=1 and out_rdy=1.
REQ-019 When the output slot is free and any pend bit is set, the block SHALL load one channel into out_data/out_ch and set out_vld=1 in the next cycle.
REQ-020 The loaded channel SHALL be selected round-robin: the first pend channel at or after ptr, searching upward and wrapping from 3 to 0.
REQ-021 After each grant, ptr SHALL become (granted channel + 1) mod 4.
REQ-022 The minimum latency from a ch_vld pulse to out_vld is 2 cycles: capture into pend, then load into the output.
REQ-023 While out_vld=1 and out_rdy=0, out_data, out_ch and out_vld SHALL hold stable.
REQ-024 When the slot is free and no pend bit is set, out_vld SHALL go to 0 in the next cycle.
REQ-025 A granted channel SHALL have its pend bit cleared, unless a new capture on that channel occurs in the same cycle.
  - In that case the old data goes to the output, the new data is stored, pend stays 1, and no overflow is raised.
REQ-026 A capture on channel i while pend[i]=1 and channel i is not granted in that cycle is an overrun.
  - The holding register is overwritten with the new data.
  - ovf[i] is set.
  - drop_cnt[i] increments and saturates at all-ones.
REQ-027 When cfg_ch_en[i] falls, pend[i] SHALL clear in the next cycle; a sample already loaded into the output is still delivered.
REQ-028 ovf_clr SHALL zero ovf and drop_cnt in the next cycle.
  - If an overrun occurs in the same cycle as ovf_clr, the overrun wins: the flag is set and the counter is 1.
REQ-029 All arithmetic SHALL be unsigned, with no sign extension.

Reset
REQ-030 While rst=1, pend, ptr, holding registers, out_data, out_ch, out_vld, ovf and drop_cnt SHALL all be 0 from the next clock edge.
REQ-031 A reset asserted mid-transfer SHALL discard held and pending samples; no partial output follows reset release.
REQ-032 ch_vld pulses that arrive while rst=1 SHALL be ignored.

Configuration
REQ-033 Macro AD_SCH_STAT_EN defined: drop_cnt SHALL be implemented as specified in REQ-026 and REQ-028.
REQ-034 Macro AD_SCH_STAT_EN undefined: drop_cnt SHALL be a constant 0 and no counter logic is built; ovf behaviour is unchanged.

Verification
REQ-035 Single sample: cfg_ch_en=4'hF, out_rdy=1, ch_vld=4'b0100 with ch2 data=24'h222222 at cycle N -> out_vld=1, out_ch=2, out_data=24'h222222 at N+2, then out_vld=0 at N+3.
REQ-036 Round-robin: ch_vld=4'hF in one cycle with data 24'h111111..24'h444444 and ptr=0 -> out_ch sequence 0,1,2,3 on consecutive cycles, no overflow.
REQ-037 Backpressure: out_rdy=0 for 10 cycles after the first grant -> out_data/out_ch stay stable throughout; sample order is unchanged after out_rdy=1.
REQ-038 Overrun: out_rdy=0; ch1 pulsed with 24'h000001 and then 24'h000002 -> ovf=4'b0010 and drop_cnt[1]=1 (with the macro); after out_rdy=1 the 24'h000002 sample is delivered.
REQ-039 Same-cycle grant plus capture: ch0 pending and granted while ch_vld[0] pulses with 24'hABCDEF -> old data is output, ovf[0]=0, and 24'hABCDEF is output on a later grant.
REQ-040 Disable and reset: cfg_ch_en[3] cleared while ch3 is pending -> no output on ch3; rst asserted mid-stream -> all outputs are 0 on the next edge.

Source files
------------

// File: rtl/ad_sch_if.sv
// ad_sch_if: sample inputs, channel config, scheduled valid/ready output and overflow status of ad_sch.
// The master modport is the driving side (sources and sink); the slave modport is the scheduler.
interface ad_sch_if #(
  parameter int DW    = 24,
  parameter int CNT_W = 16
);
  logic [4*DW-1:0]    ch_data;
  logic [3:0]         ch_vld;
  logic [3:0]         cfg_ch_en;
  logic               ovf_clr;
  logic [DW-1:0]      out_data;
  logic [1:0]         out_ch;
  logic               out_vld;
  logic               out_rdy;
  logic [3:0]         ovf;
  logic [4*CNT_W-1:0] drop_cnt;

  modport master (
    output ch_data, ch_vld, cfg_ch_en, ovf_clr, out_rdy,
    input  out_data, out_ch, out_vld, ovf, drop_cnt
  );

  modport slave (
    input  ch_data, ch_vld, cfg_ch_en, ovf_clr, out_rdy,
    output out_data, out_ch, out_vld, ovf, drop_cnt
  );
endinterface

// File: rtl/ad_sch.sv
// ad_sch: 4-channel scheduler, one-deep hold per channel, round-robin onto valid/ready; 2 cycles strobe-to-out_vld,
// output holds while out_rdy=0 and a re-capture on a pending channel is an overrun. Drop counters only with AD_SCH_STAT_EN.
module ad_sch #(
  parameter int DW    = 24,
  parameter int CNT_W = 16
) (
  input logic     clk_sys,
  input logic     rst,
  ad_sch_if.slave bus
);
  logic [DW-1:0] hold [4];
  logic [3:0]    pend;
  logic [3:0]    cap;
  logic [3:0]    elig;
  logic [3:0]    ovr;
  logic [3:0]    ovf_q;
  logic [1:0]    ptr;
  logic [1:0]    gnt;
  logic          gnt_vld;
  logic          slot_free;
  logic          take;
  logic [DW-1:0] out_data_q;
  logic [1:0]    out_ch_q;
  logic          out_vld_q;

  assign cap       = bus.ch_vld & bus.cfg_ch_en;
  // A channel being disabled is never granted, even in the cycle its pend bit is still set.
  assign elig      = pend & bus.cfg_ch_en;
  assign slot_free = !out_vld_q || bus.out_rdy;
  assign take      = slot_free && gnt_vld;

  always_comb begin
    gnt     = ptr;
    gnt_vld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!gnt_vld && elig[ptr + 2'(k)]) begin
        gnt     = ptr + 2'(k);
        gnt_vld = 1'b1;
      end
    end
  end

  always_comb begin
    ovr = '0;
    for (int i = 0; i < 4; i++) begin
      ovr[i] = cap[i] && pend[i] && !(take && gnt == 2'(i));
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      pend       <= '0;
      ptr        <= '0;
      ovf_q      <= '0;
      out_data_q <= '0;
      out_ch_q   <= '0;
      out_vld_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        hold[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (cap[i]) begin
          hold[i] <= bus.ch_data[i*DW +: DW];
        end
        if (!bus.cfg_ch_en[i]) begin
          pend[i] <= 1'b0;
        end else if (cap[i]) begin
          pend[i] <= 1'b1;
        end else if (take && gnt == 2'(i)) begin
          pend[i] <= 1'b0;
        end
      end
      // An overrun in the clear cycle survives the clear.
      ovf_q <= (bus.ovf_clr ? 4'b0000 : ovf_q) | ovr;
      if (slot_free) begin
        if (take) begin
          out_data_q <= hold[gnt];
          out_ch_q   <= gnt;
          out_vld_q  <= 1'b1;
          ptr        <= gnt + 2'd1;
        end else begin
          out_vld_q  <= 1'b0;
        end
      end
    end
  end

  assign bus.out_data = out_data_q;
  assign bus.out_ch   = out_ch_q;
  assign bus.out_vld  = out_vld_q;
  assign bus.ovf      = ovf_q;

`ifdef AD_SCH_STAT_EN
  logic [4*CNT_W-1:0] cnt;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (ovr[i]) begin
          if (bus.ovf_clr) begin
            cnt[i*CNT_W +: CNT_W] <= CNT_W'(1);
          end else if (!(&cnt[i*CNT_W +: CNT_W])) begin
            cnt[i*CNT_W +: CNT_W] <= cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
          end
        end else if (bus.ovf_clr) begin
          cnt[i*CNT_W +: CNT_W] <= '0;
        end
      end
    end
  end

  assign bus.drop_cnt = cnt;
`else
  assign bus.drop_cnt = {(4*CNT_W){1'b0}};
`endif

endmodule

// File: tb/tb_ad_sch.sv
// tb_ad_sch: directed stimulus for ad_sch; expected {ch,data} pairs are queued when samples are driven
// and popped by a monitor on every output handshake, with cycle-exact checks of timing, overrun and reset.
module tb_ad_sch;
  localparam int DW    = 24;
  localparam int CNT_W = 16;

`ifdef AD_SCH_STAT_EN
  localparam logic [CNT_W-1:0] DROP_ONE = CNT_W'(1);
`else
  localparam logic [CNT_W-1:0] DROP_ONE = '0;
`endif

  logic clk_sys = 1'b0;
  logic rst     = 1'b1;

  ad_sch_if #(.DW(DW), .CNT_W(CNT_W)) bus ();

  ad_sch #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk_sys (clk_sys),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int n_chk  = 0;
  int n_fail = 0;
  logic [DW+1:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic pulse(input int ch, input logic [DW-1:0] d);
    bus.ch_vld               = 4'b0001 << ch;
    bus.ch_data[ch*DW +: DW] = d;
  endtask

  // Every accepted output must be the oldest outstanding expectation.
  always @(negedge clk_sys) begin
    if (!rst && bus.out_vld === 1'b1 && bus.out_rdy === 1'b1) begin
      logic [DW+1:0] e;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else                   e = 'x;
      check("sb_out", 64'({bus.out_ch, bus.out_data}), 64'(e));
    end
  end

  initial begin
    bus.ch_data   = '0;
    bus.ch_vld    = 4'h0;
    bus.cfg_ch_en = 4'hF;
    bus.ovf_clr   = 1'b0;
    bus.out_rdy   = 1'b1;

    // Reset, with strobes that must be ignored
    rst         = 1'b1;
    bus.ch_vld  = 4'hF;
    bus.ch_data = {4{24'h5A5A5A}};
    repeat (3) step();
    check("rst_out_vld",  64'(bus.out_vld),  64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_out_ch",   64'(bus.out_ch),   64'd0);
    check("rst_ovf",      64'(bus.ovf),      64'd0);
    check("rst_drop",     64'(bus.drop_cnt), 64'd0);
    rst        = 1'b0;
    bus.ch_vld = 4'h0;
    step();
    step();
    check("post_rst_idle", 64'(bus.out_vld), 64'd0);

    // Single sample latency
    pulse(2, 24'h222222);
    exp_q.push_back({2'd2, 24'h222222});
    step();
    bus.ch_vld = 4'h0;
    check("single_n1_vld", 64'(bus.out_vld), 64'd0);
    step();
    check("single_vld",  64'(bus.out_vld),  64'd1);
    check("single_ch",   64'(bus.out_ch),   64'd2);
    check("single_data", 64'(bus.out_data), 64'h222222);
    step();
    check("single_n3_vld", 64'(bus.out_vld), 64'd0);

    // Grant ch3 once so the pointer wraps to 0
    pulse(3, 24'h333000);
    exp_q.push_back({2'd3, 24'h333000});
    step();
    bus.ch_vld = 4'h0;
    step();
    step();

    // Round robin from ptr=0
    bus.ch_vld  = 4'hF;
    bus.ch_data = {24'h444444, 24'h333333, 24'h222222, 24'h111111};
    exp_q.push_back({2'd0, 24'h111111});
    exp_q.push_back({2'd1, 24'h222222});
    exp_q.push_back({2'd2, 24'h333333});
    exp_q.push_back({2'd3, 24'h444444});
    step();
    bus.ch_vld = 4'h0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr_vld", 64'(bus.out_vld), 64'd1);
      check("rr_ch",  64'(bus.out_ch),  64'(i));
    end
    step();
    check("rr_idle", 64'(bus.out_vld), 64'd0);
    check("rr_ovf",  64'(bus.ovf),     64'd0);

    // Backpressure: output stable for 10 cycles, order preserved
    bus.ch_vld               = 4'b0011;
    bus.ch_data[0*DW +: DW]  = 24'hB00000;
    bus.ch_data[1*DW +: DW]  = 24'hB11111;
    exp_q.push_back({2'd0, 24'hB00000});
    exp_q.push_back({2'd1, 24'hB11111});
    step();
    bus.ch_vld = 4'h0;
    step();
    bus.out_rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_vld",  64'(bus.out_vld),  64'd1);
      check("bp_ch",   64'(bus.out_ch),   64'd0);
      check("bp_data", 64'(bus.out_data), 64'hB00000);
    end
    bus.out_rdy = 1'b1;
    step();
    check("bp_after_ch", 64'(bus.out_ch), 64'd1);
    step();
    check("bp_idle", 64'(bus.out_vld), 64'd0);

    // Overrun on ch1 while the output is blocked
    bus.out_rdy = 1'b0;
    pulse(0, 24'h0F0F0F);
    exp_q.push_back({2'd0, 24'h0F0F0F});
    step();
    bus.ch_vld = 4'h0;
    step();
    pulse(1, 24'h000001);
    step();
    pulse(1, 24'h000002);
    step();
    bus.ch_vld = 4'h0;
    check("ovr_ovf",  64'(bus.ovf), 64'b0010);
    check("ovr_drop", 64'(bus.drop_cnt[1*CNT_W +: CNT_W]), 64'(DROP_ONE));
    exp_q.push_back({2'd1, 24'h000002});
    bus.out_rdy = 1'b1;
    step();
    check("ovr_ch",   64'(bus.out_ch),   64'd1);
    check("ovr_data", 64'(bus.out_data), 64'h000002);
    step();
    check("ovr_idle", 64'(bus.out_vld), 64'd0);
    bus.ovf_clr = 1'b1;
    step();
    bus.ovf_clr = 1'b0;
    check("clr_ovf",  64'(bus.ovf),      64'd0);
    check("clr_drop", 64'(bus.drop_cnt), 64'd0);

    // Overrun in the same cycle as ovf_clr wins
    bus.out_rdy = 1'b0;
    pulse(2, 24'h0000A1);
    exp_q.push_back({2'd2, 24'h0000A1});
    step();
    bus.ch_vld = 4'h0;
    step();
    pulse(2, 24'h0000A2);
    step();
    pulse(2, 24'h0000A3);
    bus.ovf_clr = 1'b1;
    step();
    bus.ch_vld  = 4'h0;
    bus.ovf_clr = 1'b0;
    check("win_ovf",  64'(bus.ovf), 64'b0100);
    check("win_drop", 64'(bus.drop_cnt[2*CNT_W +: CNT_W]), 64'(DROP_ONE));
    exp_q.push_back({2'd2, 24'h0000A3});
    bus.out_rdy = 1'b1;
    step();
    step();
    check("win_idle", 64'(bus.out_vld), 64'd0);
    bus.ovf_clr = 1'b1;
    step();
    bus.ovf_clr = 1'b0;

    // Grant and capture on ch0 in the same cycle
    pulse(0, 24'h123456);
    exp_q.push_back({2'd0, 24'h123456});
    step();
    pulse(0, 24'hABCDEF);
    exp_q.push_back({2'd0, 24'hABCDEF});
    step();
    bus.ch_vld = 4'h0;
    check("sc_ch",   64'(bus.out_ch),   64'd0);
    check("sc_data", 64'(bus.out_data), 64'h123456);
    check("sc_ovf",  64'(bus.ovf),      64'd0);
    step();
    check("sc_data2", 64'(bus.out_data), 64'hABCDEF);
    check("sc_vld2",  64'(bus.out_vld),  64'd1);
    step();
    check("sc_idle", 64'(bus.out_vld), 64'd0);

    // Disabling ch3 while pending drops it
    bus.out_rdy = 1'b0;
    pulse(0, 24'h0C0C0C);
    exp_q.push_back({2'd0, 24'h0C0C0C});
    step();
    bus.ch_vld = 4'h0;
    step();
    pulse(3, 24'h333333);
    step();
    bus.ch_vld    = 4'h0;
    bus.cfg_ch_en = 4'b0111;
    step();
    bus.cfg_ch_en = 4'hF;
    bus.out_rdy   = 1'b1;
    step();
    check("dis_idle", 64'(bus.out_vld), 64'd0);
    step();
    check("dis_idle2", 64'(bus.out_vld), 64'd0);
    check("dis_ovf",   64'(bus.ovf),     64'd0);

    // Reset mid-stream discards everything
    bus.out_rdy             = 1'b0;
    bus.ch_vld              = 4'b0110;
    bus.ch_data[1*DW +: DW] = 24'h611111;
    bus.ch_data[2*DW +: DW] = 24'h622222;
    step();
    bus.ch_vld = 4'h0;
    step();
    pulse(2, 24'h777777);
    step();
    bus.ch_vld = 4'h0;
    check("pre_rst_vld", 64'(bus.out_vld), 64'd1);
    check("pre_rst_ovf", 64'(bus.ovf),     64'b0100);
    rst = 1'b1;
    step();
    check("mr_vld",  64'(bus.out_vld),  64'd0);
    check("mr_data", 64'(bus.out_data), 64'd0);
    check("mr_ch",   64'(bus.out_ch),   64'd0);
    check("mr_ovf",  64'(bus.ovf),      64'd0);
    check("mr_drop", 64'(bus.drop_cnt), 64'd0);
    rst         = 1'b0;
    bus.out_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("mr_after_vld", 64'(bus.out_vld), 64'd0);
    end

    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
